// File: rtl/aes_inv_cipher_iter.sv
// Purpose : iterative AES-128 decryption engine, one round per clock on a shared datapath.
// Latency : without a cache hit, out_valid rises on the 21st edge counting the accept edge as the first.
//           That is 10 key-expansion edges, 9 inverse rounds and 1 final round after the accept edge.
//           With a KEY_CACHE_EN cache hit, it rises on the 11th edge.
// Backpr. : one block in flight; in_ready is low from accept until the result is popped.
//           out_valid/out_data hold until out_ready.
// Ports   : clk, rst (async, active-high); in_valid/in_ready/in_data/in_key (ciphertext + key in);
//           out_valid/out_ready/out_data (plaintext out); busy (KEYEXP or DEC).
// Byte order: byte 0 at [127:120], column-major (column 0 = [127:96]).
// Optional: define KEY_CACHE_EN to remember the last key and its round-10 key, skipping KEYEXP on reuse.
module aes_inv_cipher_iter #(
  parameter logic SCRUB_ON_POP = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, KEYEXP, DEC, DONE} state_t;

  state_t        state_q, state_d;
  logic [127:0]  data_q, data_d;
  logic [127:0]  key_q, key_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [127:0]  out_data_q, out_data_d;

  // ---------------------------------------------------------------- GF / S-box helpers
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    row = '0;
    case (b[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    // Low nibble selects the byte within the row; byte 0 sits in the top bits.
    return row[{~b[3:0], 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [127:0] row;
    row = '0;
    case (b[7:4])
      4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      default: row = 128'h172b047eba77d626e169146355210c7d;
    endcase
    return row[{~b[3:0], 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  // ---------------------------------------------------------------- round transforms
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    // Row r rotates right by r columns: out[r][c] = in[r][c-r].
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c-r+4)%4)+r)) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
      o[119-32*c -: 8] = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
      o[111-32*c -: 8] = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
      o[103-32*c -: 8] = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------- key schedule
  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:  return 8'h01;
      4'd2:  return 8'h02;
      4'd3:  return 8'h04;
      4'd4:  return 8'h08;
      4'd5:  return 8'h10;
      4'd6:  return 8'h20;
      4'd7:  return 8'h40;
      4'd8:  return 8'h80;
      4'd9:  return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
  endfunction

  function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Steps the schedule backwards: recovers round key i-1 from round key i.
  function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  // ---------------------------------------------------------------- shared datapath
  logic         accept;
  logic         cache_hit;
  logic [127:0] rk_fwd, rk_inv, inv_sr_sb;

  assign accept    = in_valid & in_ready;
  assign rk_fwd    = fwd_expand(key_q, rcon(cnt_q));
  // cnt+1 selects the Rcon that produced the key being undone; cnt==0 gives Rcon(1) -> rk0.
  assign rk_inv    = inv_expand(key_q, rcon(cnt_q + 4'd1));
  assign inv_sr_sb = inv_sub_bytes(inv_shift_rows(data_q));

`ifdef KEY_CACHE_EN
  logic [127:0] cached_key_q, cached_key_d;
  logic [127:0] cached_rk10_q, cached_rk10_d;
  logic         cache_vld_q, cache_vld_d;

  assign cache_hit = accept & cache_vld_q & (in_key == cached_key_q);
`else
  assign cache_hit = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      data_q        <= '0;
      key_q         <= '0;
      cnt_q         <= '0;
      out_data_q    <= '0;
`ifdef KEY_CACHE_EN
      cached_key_q  <= '0;
      cached_rk10_q <= '0;
      cache_vld_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      key_q         <= key_d;
      cnt_q         <= cnt_d;
      out_data_q    <= out_data_d;
`ifdef KEY_CACHE_EN
      cached_key_q  <= cached_key_d;
      cached_rk10_q <= cached_rk10_d;
      cache_vld_q   <= cache_vld_d;
`endif
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = cache_hit ? DEC : KEYEXP;
      KEYEXP:  if (cnt_q == 4'd10) state_d = DEC;
      DEC:     if (cnt_q == 4'd0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    // State is already IDLE during reset, so gate with rst to hold in_ready low.
    in_ready  = (state_q == IDLE) & ~rst;
    out_valid = (state_q == DONE);
    busy      = (state_q == KEYEXP) | (state_q == DEC);
    out_data  = out_data_q;
  end

  // ---------------------------------------------------------------- datapath next values
  always_comb begin
    data_d     = data_q;
    key_d      = key_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
`ifdef KEY_CACHE_EN
    cached_key_d  = cached_key_q;
    cached_rk10_d = cached_rk10_q;
    cache_vld_d   = cache_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d = in_data;
          key_d  = in_key;
          cnt_d  = 4'd1;
`ifdef KEY_CACHE_EN
          if (cache_hit) begin
            data_d = in_data ^ cached_rk10_q;
            key_d  = cached_rk10_q;
            cnt_d  = 4'd9;
          end else begin
            // The key register is overwritten during expansion, so capture the
            // original key now and mark the entry valid only once rk10 is known.
            cached_key_d = in_key;
            cache_vld_d  = 1'b0;
          end
`endif
        end
      end
      KEYEXP: begin
        key_d = rk_fwd;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          data_d = data_q ^ rk_fwd;
          cnt_d  = 4'd9;
`ifdef KEY_CACHE_EN
          cached_rk10_d = rk_fwd;
          cache_vld_d   = 1'b1;
`endif
        end
      end
      DEC: begin
        if (cnt_q != 4'd0) begin
          data_d = inv_mix_columns(inv_sr_sb ^ rk_inv);
          key_d  = rk_inv;
          cnt_d  = cnt_q - 4'd1;
        end else begin
          out_data_d = inv_sr_sb ^ rk_inv;
        end
      end
      DONE: begin
        if (out_ready && SCRUB_ON_POP) out_data_d = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: FIPS-197 vectors, latency, backpressure,
// mid-operation reset, input-ignored-while-busy and (when KEY_CACHE_EN) key reuse.
// Latencies are counted in clock edges with the accept edge numbered 1.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef KEY_CACHE_EN
  localparam int LAT_REPEAT = 11;
`else
  localparam int LAT_REPEAT = 21;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  aes_inv_cipher_iter #(.SCRUB_ON_POP(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a block at a negedge; returns #1 after the accept edge.
  task automatic accept(input logic [127:0] d, input logic [127:0] k);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_key   = k;
    check("accept_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid; lat counts edges with the accept edge as 1. Optionally pulses
  // in_valid with garbage while busy. snap captures the key register after edge 11.
  task automatic wait_out(input int pulse_at, output int lat, output int bcnt,
                          output logic [127:0] snap);
    lat  = 1;
    bcnt = busy ? 1 : 0;
    snap = '0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (pulse_at != 0 && lat == pulse_at) begin
        in_valid = 1'b1;
        in_data  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        in_key   = 128'hffeeddccbbaa99887766554433221100;
      end
      if (pulse_at != 0 && lat == pulse_at + 2) in_valid = 1'b0;
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
      if (lat == 11) snap = dut.key_q;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int           lat;
    int           bcnt;
    int           spur;
    logic [127:0] snap;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;

    // C.1, with a garbage in_valid pulse during KEYEXP
    accept(C1_CT, C1_KEY);
    wait_out(3, lat, bcnt, snap);
    check("c1_latency", 128'(lat), 128'd21);
    check("c1_busy_cycles", 128'(bcnt), 128'd20);
    check("c1_out_data", out_data, C1_PT);
    @(posedge clk);
    #1;
    check("c1_pop_out_valid", 128'(out_valid), 128'd0);
    check("c1_pop_scrub", out_data, 128'd0);
    check("c1_pop_in_ready", 128'(in_ready), 128'd1);

    // C.1 again with the same key
    accept(C1_CT, C1_KEY);
    wait_out(0, lat, bcnt, snap);
    check("c1_repeat_latency", 128'(lat), 128'(LAT_REPEAT));
    check("c1_repeat_out_data", out_data, C1_PT);
    @(posedge clk);
    #1;

    // App B with backpressure
    out_ready = 1'b0;
    accept(B_CT, B_KEY);
    wait_out(0, lat, bcnt, snap);
    check("b_latency", 128'(lat), 128'd21);
    check("b_rk10", snap, B_RK10);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_data", out_data, B_PT);
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_pop_out_valid", 128'(out_valid), 128'd0);
    check("bp_pop_scrub", out_data, 128'd0);
    check("bp_pop_in_ready", 128'(in_ready), 128'd1);

    // Reset in the middle of DEC
    accept(C1_CT, C1_KEY);
    repeat (14) @(posedge clk);
    #1;
    check("midrst_busy_before", 128'(busy), 128'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'd0);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_rel_in_ready", 128'(in_ready), 128'd1);
    spur = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) spur++;
    end
    check("midrst_no_spurious", 128'(spur), 128'd0);

    // Fresh C.1 after reset: any cached key is gone, so full latency again
    accept(C1_CT, C1_KEY);
    wait_out(0, lat, bcnt, snap);
    check("c1_after_rst_latency", 128'(lat), 128'd21);
    check("c1_after_rst_out_data", out_data, C1_PT);
    @(posedge clk);
    #1;
    check("final_out_valid", 128'(out_valid), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
